// File: rtl/risc_v_mike_mem_bus_fabric.sv
// risc_v_mike_mem_bus_fabric: N-master arbiter, region decoder and wait-state inserter for the shared memory bus.
// Define MEM_BUS_RR_ARB_EN for round-robin arbitration; fixed priority (master 0 first) otherwise.
`timescale 1ns/1ps
module risc_v_mike_mem_bus_fabric #(
   parameter int N_MST = 2,
   parameter int N_REG = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int WAIT_CYC = 1,
   parameter logic [N_REG*ADDR_W-1:0] REG_BASE = {32'hFFFF0000, 32'h00400000, 32'h7FFFF000, 32'h10010000},
   parameter logic [N_REG*ADDR_W-1:0] REG_MASK = {32'hFFFF0000, 32'hFFF00000, 32'hFFFFF000, 32'hFFFF0000}
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_MST-1:0]        m_req,
   input  logic [N_MST-1:0]        m_wr,
   input  logic [N_MST*ADDR_W-1:0] m_addr,
   input  logic [N_MST*DATA_W-1:0] m_wdata,
   output logic [N_MST-1:0]        m_ack,
   output logic [N_MST-1:0]        m_err,
   output logic [DATA_W-1:0]       m_rdata,
   output logic [N_REG-1:0]        s_sel,
   output logic                    s_wr,
   output logic [ADDR_W-1:0]       s_addr,
   output logic [DATA_W-1:0]       s_wdata,
   input  logic [N_REG*DATA_W-1:0] s_rdata,
   output logic                    busy
);
   localparam int GW = N_MST > 1 ? $clog2(N_MST) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state, nxt;
   logic [GW-1:0] gnt, pick;
   logic [N_REG-1:0] sel_q, sel_d;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] rd_mux;
   logic [3:0] wcnt;
   logic wr_q, err_q, last, start;
   assign last = wcnt == 4'(WAIT_CYC);
   assign start = state == IDLE && |m_req;
`ifdef MEM_BUS_RR_ARB_EN
   logic [GW-1:0] ptr;
   always_ff @(posedge clk or negedge rst)
      if (!rst) ptr <= '0;
      else if (start) ptr <= pick;
   // Descending scan so the requester nearest ptr+1 is the last (winning) assignment.
   always_comb begin
      pick = '0;
      for (int i = N_MST-1; i >= 0; i--)
         if (m_req[(int'(ptr) + 1 + i) % N_MST]) pick = GW'((int'(ptr) + 1 + i) % N_MST);
   end
`else
   always_comb begin
      pick = '0;
      for (int i = N_MST-1; i >= 0; i--)
         if (m_req[i]) pick = GW'(i);
   end
`endif
   // Lowest-index region wins on overlap; an all-zero select marks a decode miss.
   always_comb begin
      req_addr = m_addr[int'(pick)*ADDR_W +: ADDR_W];
      sel_d = '0;
      for (int j = N_REG-1; j >= 0; j--)
         if ((req_addr & REG_MASK[j*ADDR_W +: ADDR_W]) == REG_BASE[j*ADDR_W +: ADDR_W]) begin
            sel_d = '0;
            sel_d[j] = 1'b1;
         end
   end
   always_comb begin
      rd_mux = '0;
      for (int j = 0; j < N_REG; j++)
         if (sel_q[j]) rd_mux = rd_mux | s_rdata[j*DATA_W +: DATA_W];
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= nxt;
   always_comb
      nxt = state == IDLE ? (|m_req ? ACCESS : IDLE) :
            state == ACCESS ? (last ? RESP : ACCESS) : IDLE;
   // Strobes derive from the state register so the async reset clears them immediately.
   always_comb begin
      s_sel = state == ACCESS ? sel_q : '0;
      s_wr = state == ACCESS && last && wr_q && !err_q;
      busy = state != IDLE;
      m_ack = '0;
      m_err = '0;
      if (state == RESP) begin
         m_ack[gnt] = 1'b1;
         m_err[gnt] = err_q;
      end
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         gnt <= '0;
         wr_q <= 1'b0;
         err_q <= 1'b0;
         sel_q <= '0;
         wcnt <= '0;
         s_addr <= '0;
         s_wdata <= '0;
         m_rdata <= '0;
      end else if (start) begin
         gnt <= pick;
         wr_q <= m_wr[pick];
         err_q <= ~|sel_d;
         sel_q <= sel_d;
         wcnt <= '0;
         s_addr <= req_addr;
         s_wdata <= m_wdata[int'(pick)*DATA_W +: DATA_W];
      end else if (state == ACCESS) begin
         wcnt <= wcnt + 4'd1;
         if (last) m_rdata <= (wr_q || err_q) ? '0 : rd_mux;
      end
endmodule

// File: tb/tb_risc_v_mike_mem_bus_fabric.sv
// tb_risc_v_mike_mem_bus_fabric: randomized bench for the memory-bus fabric against a region-table reference model.
`timescale 1ns/1ps
module tb_risc_v_mike_mem_bus_fabric;
   localparam int N_MST = 2;
   localparam int WAIT_CYC = 1;
   localparam logic [31:0] BASE [4] = '{32'h10010000, 32'h7FFFF000, 32'h00400000, 32'hFFFF0000};
   localparam logic [31:0] MASK [4] = '{32'hFFFF0000, 32'hFFFFF000, 32'hFFF00000, 32'hFFFF0000};
   logic clk = 0, rst = 0;
   logic [1:0] m_req = '0, m_wr = '0, m_ack, m_err;
   logic [63:0] m_addr = '0, m_wdata = '0;
   logic [31:0] m_rdata, s_addr, s_wdata;
   logic [3:0] s_sel;
   logic s_wr, busy;
   logic [127:0] s_rdata = '0;
   logic [31:0] rd [4];
   int checks = 0, errors = 0, last_gnt = 0;
   risc_v_mike_mem_bus_fabric #(.N_MST(N_MST), .WAIT_CYC(WAIT_CYC)) dut (
      .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata), .s_sel(s_sel), .s_wr(s_wr),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .busy(busy));
   always #5 clk = ~clk;
   function automatic int region(input logic [31:0] a);
      for (int j = 0; j < 4; j++)
         if ((a & MASK[j]) == BASE[j]) return j;
      return -1;
   endfunction
   task automatic set_rdata();
      for (int j = 0; j < 4; j++) s_rdata[j*32 +: 32] = rd[j];
   endtask
   task automatic wait_idle();
      int g = 0;
      @(negedge clk);
      while (busy && g < 50) begin
         @(negedge clk);
         g++;
      end
   endtask
   // Drives one request from an idle bus and records what the bus did; the callers judge it.
   task automatic run_txn(input int mst, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [3:0] sel_or, output int sel_cyc, output int wr_cnt,
                          output logic [31:0] wdat, output logic [31:0] saddr, output logic [1:0] ack,
                          output logic [1:0] err, output logic [31:0] rdata);
      wait_idle();
      m_req[mst] = 1'b1;
      m_wr[mst] = wr;
      m_addr[mst*32 +: 32] = addr;
      m_wdata[mst*32 +: 32] = wdata;
      lat = 1; sel_or = '0; sel_cyc = 0; wr_cnt = 0; wdat = '0; saddr = '0; ack = '0; err = '0; rdata = '0;
      while (lat < 40) begin
         @(posedge clk); #1; lat++;
         if (s_sel != 0) begin sel_or |= s_sel; sel_cyc++; saddr = s_addr; end
         if (s_wr) begin wr_cnt++; wdat = s_wdata; end
         if (m_ack != 0) begin ack = m_ack; err = m_err; rdata = m_rdata; break; end
      end
      m_req[mst] = 1'b0;
   endtask
   task automatic test_reset();
      rst = 0;
      m_req = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (m_ack !== 2'b0 || m_err !== 2'b0) begin errors++; $display("FAIL reset_ack got %b/%b exp 00/00", m_ack, m_err); end
      checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", m_rdata); end
      checks++; if (s_sel !== 4'h0 || s_wr !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b/%b exp 0000/0", s_sel, s_wr); end
      checks++; if (s_addr !== 32'h0 || s_wdata !== 32'h0) begin errors++; $display("FAIL reset_latch got %h/%h exp 0/0", s_addr, s_wdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      @(negedge clk);
      rst = 1;
      last_gnt = 0;
   endtask
   task automatic test_read();
      int lat, sc, wc; logic [3:0] so; logic [31:0] wd, sa, rdv; logic [1:0] ak, er;
      rd[0] = 32'hDEADBEEF; rd[1] = 32'h11111111; rd[2] = 32'h22222222; rd[3] = 32'h33333333;
      set_rdata();
      run_txn(1, 0, 32'h10010008, 32'h0, lat, so, sc, wc, wd, sa, ak, er, rdv);
      last_gnt = 1;
      checks++; if (so !== 4'b0001 || sc !== WAIT_CYC+1) begin errors++; $display("FAIL read_sel got %b x%0d exp 0001 x%0d", so, sc, WAIT_CYC+1); end
      checks++; if (lat !== WAIT_CYC+3) begin errors++; $display("FAIL read_latency got %0d exp %0d", lat, WAIT_CYC+3); end
      checks++; if (ak !== 2'b10 || er !== 2'b00) begin errors++; $display("FAIL read_ack got %b/%b exp 10/00", ak, er); end
      checks++; if (rdv !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got %h exp deadbeef", rdv); end
      checks++; if (sa !== 32'h10010008 || wc !== 0) begin errors++; $display("FAIL read_addr got %h wr%0d exp 10010008 wr0", sa, wc); end
   endtask
   task automatic test_miss();
      int lat, sc, wc; logic [3:0] so; logic [31:0] wd, sa, rdv; logic [1:0] ak, er;
      run_txn(0, 0, 32'h20000000, 32'h0, lat, so, sc, wc, wd, sa, ak, er, rdv);
      last_gnt = 0;
      checks++; if (so !== 4'b0 || wc !== 0) begin errors++; $display("FAIL miss_sel got %b wr%0d exp 0000 wr0", so, wc); end
      checks++; if (ak !== 2'b01 || er !== 2'b01) begin errors++; $display("FAIL miss_err got %b/%b exp 01/01", ak, er); end
      checks++; if (rdv !== 32'h0) begin errors++; $display("FAIL miss_rdata got %h exp 0", rdv); end
      run_txn(1, 1, 32'h20000000, 32'h55AA55AA, lat, so, sc, wc, wd, sa, ak, er, rdv);
      last_gnt = 1;
      checks++; if (wc !== 0 || ak !== 2'b10 || er !== 2'b10) begin errors++; $display("FAIL miss_write got wr%0d %b/%b exp wr0 10/10", wc, ak, er); end
   endtask
   task automatic test_write();
      int lat, sc, wc; logic [3:0] so; logic [31:0] wd, sa, rdv; logic [1:0] ak, er;
      run_txn(0, 0, 32'h10010000, 32'h0, lat, so, sc, wc, wd, sa, ak, er, rdv);
      run_txn(1, 1, 32'h7FFFFFFC, 32'hCAFE0001, lat, so, sc, wc, wd, sa, ak, er, rdv);
      last_gnt = 1;
      checks++; if (so !== 4'b0010) begin errors++; $display("FAIL write_sel got %b exp 0010", so); end
      checks++; if (wc !== 1 || wd !== 32'hCAFE0001) begin errors++; $display("FAIL write_strobe got x%0d %h exp x1 cafe0001", wc, wd); end
      checks++; if (ak !== 2'b10 || er !== 2'b00 || rdv !== 32'h0) begin errors++; $display("FAIL write_ack got %b/%b %h exp 10/00 0", ak, er, rdv); end
   endtask
   task automatic test_mmio();
      int lat, sc, wc; logic [3:0] so; logic [31:0] wd, sa, rdv; logic [1:0] ak, er;
      rd[3] = 32'h0BADF00D;
      set_rdata();
      run_txn(0, 0, 32'hFFFF0004, 32'h0, lat, so, sc, wc, wd, sa, ak, er, rdv);
      last_gnt = 0;
      checks++; if (so !== 4'b1000 || lat !== WAIT_CYC+3) begin errors++; $display("FAIL mmio got %b lat%0d exp 1000 lat%0d", so, lat, WAIT_CYC+3); end
      checks++; if (rdv !== 32'h0BADF00D) begin errors++; $display("FAIL mmio_data got %h exp 0badf00d", rdv); end
   endtask
   task automatic test_random();
      int lat, sc, wc, mst, k, r; bit wr; logic [3:0] so, es; logic [31:0] wd, sa, rdv, a, d, ed; logic [1:0] ak, er, em;
      for (int n = 0; n < 40; n++) begin
         for (int j = 0; j < 4; j++) rd[j] = $urandom;
         set_rdata();
         mst = $urandom_range(0, 1);
         wr = 1'($urandom_range(0, 1));
         k = $urandom_range(0, 4);
         a = k < 4 ? (BASE[k] | ($urandom & ~MASK[k])) : $urandom;
         d = $urandom;
         run_txn(mst, wr, a, d, lat, so, sc, wc, wd, sa, ak, er, rdv);
         last_gnt = mst;
         r = region(a);
         es = r < 0 ? 4'b0 : 4'(1 << r);
         ed = (wr || r < 0) ? 32'h0 : rd[r];
         em = 2'(1 << mst);
         checks++; if (so !== es || (r >= 0 && sc !== WAIT_CYC+1)) begin errors++; $display("FAIL rand%0d_sel addr %h got %b x%0d exp %b", n, a, so, sc, es); end
         checks++; if (ak !== em || er !== (r < 0 ? em : 2'b0)) begin errors++; $display("FAIL rand%0d_ack got %b/%b exp %b err%0d", n, ak, er, em, r < 0); end
         checks++; if (rdv !== ed || lat !== WAIT_CYC+3) begin errors++; $display("FAIL rand%0d_data got %h lat%0d exp %h lat%0d", n, rdv, lat, ed, WAIT_CYC+3); end
         checks++; if (wc !== ((wr && r >= 0) ? 1 : 0) || (wc == 1 && (wd !== d || sa !== a))) begin errors++; $display("FAIL rand%0d_wr got x%0d %h@%h exp %h@%h", n, wc, wd, sa, d, a); end
      end
   endtask
   task automatic test_contention();
      int got = 0, guard = 0, g, ex; bit idle_seen = 1;
      wait_idle();
      m_wr = 2'b00;
      m_addr = {32'h10010004, 32'h10010000};
      m_req = 2'b11;
      while (got < 4 && guard < 200) begin
         @(posedge clk); #1; guard++;
         if (!busy) idle_seen = 1;
         if (m_ack != 0) begin
            g = m_ack[1] ? 1 : 0;
`ifdef MEM_BUS_RR_ARB_EN
            ex = (last_gnt + 1) % N_MST;
`else
            ex = 0;
`endif
            checks++; if (g !== ex || !$onehot(m_ack)) begin errors++; $display("FAIL contend%0d_grant got %b exp master %0d", got, m_ack, ex); end
            checks++; if (!idle_seen) begin errors++; $display("FAIL contend%0d_gap got no idle cycle exp one", got); end
            idle_seen = 0;
            last_gnt = g;
            got++;
         end
      end
      m_req = 2'b00;
      checks++; if (got !== 4) begin errors++; $display("FAIL contend_count got %0d exp 4", got); end
   endtask
   task automatic test_drop();
      int lat = 1;
      wait_idle();
      m_wr[0] = 1'b0;
      m_addr[31:0] = 32'h00400010;
      m_req[0] = 1'b1;
      @(posedge clk); #1; lat++;
      m_req[0] = 1'b0;
      while (m_ack == 0 && lat < 40) begin @(posedge clk); #1; lat++; end
      last_gnt = 0;
      checks++; if (m_ack !== 2'b01 || m_rdata !== rd[2] || lat !== WAIT_CYC+3) begin errors++; $display("FAIL drop got %b %h lat%0d exp 01 %h lat%0d", m_ack, m_rdata, lat, rd[2], WAIT_CYC+3); end
   endtask
   task automatic test_reset_mid();
      int g = 0, acks = 0, lat, sc, wc; logic [3:0] so; logic [31:0] wd, sa, rdv; logic [1:0] ak, er;
      wait_idle();
      m_wr[1] = 1'b1;
      m_addr[63:32] = 32'h10010020;
      m_wdata[63:32] = 32'h12345678;
      m_req[1] = 1'b1;
      while (s_sel == 0 && g < 20) begin @(posedge clk); #1; g++; end
      #1 rst = 0;
      #1;
      checks++; if (s_sel !== 4'b0 || s_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_async got %b/%b/%b exp 0000/0/0", s_sel, s_wr, busy); end
      m_req = 2'b00;
      repeat (3) begin @(posedge clk); #1; if (m_ack != 0) acks++; end
      @(negedge clk);
      rst = 1;
      last_gnt = 0;
      repeat (3) begin @(posedge clk); #1; if (m_ack != 0) acks++; end
      checks++; if (acks !== 0) begin errors++; $display("FAIL midreset_ack got %0d acks exp 0", acks); end
      rd[0] = 32'hA5A5F00F;
      set_rdata();
      run_txn(1, 0, 32'h10010020, 32'h0, lat, so, sc, wc, wd, sa, ak, er, rdv);
      last_gnt = 1;
      checks++; if (ak !== 2'b10 || rdv !== 32'hA5A5F00F || lat !== WAIT_CYC+3) begin errors++; $display("FAIL midreset_after got %b %h lat%0d exp 10 a5a5f00f lat%0d", ak, rdv, lat, WAIT_CYC+3); end
   endtask
   initial begin
      test_reset();
      test_read();
      test_miss();
      test_write();
      test_mmio();
      test_random();
      test_contention();
      test_drop();
      test_reset_mid();
      test_contention();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/risc_v_mike_mem_bus_fabric.md
Name: risc_v_mike_mem_bus_fabric

Overview:
Parametrised memory-bus fabric for the next-generation multicycle core. It arbitrates N_MST requesters (instruction fetch, data port, future DMA) onto a single shared transaction path. It decodes the granted address against N_REG parametrised regions (text, data, stack, MMIO) and inserts per-fabric wait states. It returns read data or a decode error through a req/ack handshake, replacing the core-top fixed one-hot region mux and always-on read.

Parameters:
N_MST, 2, number of requesting masters (1..8)
N_REG, 4, number of decoded slave regions (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width
WAIT_CYC, 1, wait states inserted in ACCESS before sampling slave rdata (0..15)
REG_BASE, {32'hFFFF0000,32'h00400000,32'h7FFFF000,32'h10010000}, packed N_REG*ADDR_W region base addresses; region 0 is the LSB slice
REG_MASK, {32'hFFFF0000,32'hFFF00000,32'hFFFFF000,32'hFFFF0000}, packed N_REG*ADDR_W masks; hit when (addr & mask) == base

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
m_req  in  N_MST  per-master request, held until m_ack
m_wr  in  N_MST  per-master write (1) / read (0)
m_addr  in  N_MST*ADDR_W  per-master address
m_wdata  in  N_MST*DATA_W  per-master write data
m_ack  out  N_MST  one-cycle completion pulse to the granted master
m_err  out  N_MST  qualified by m_ack; set on decode miss
m_rdata  out  DATA_W  read data, valid in the m_ack cycle
s_sel  out  N_REG  one-hot region strobe, held throughout ACCESS
s_wr  out  1  write strobe, asserted only in the final ACCESS cycle of a write
s_addr  out  ADDR_W  latched transaction address, offset not stripped
s_wdata  out  DATA_W  latched write data
s_rdata  in  N_REG*DATA_W  per-region read data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; m_ack=0, m_err=0, m_rdata=0, s_sel=0, s_wr=0, s_addr=0, s_wdata=0, busy=0; round-robin pointer = 0.
- FSM states are IDLE, ACCESS, RESP.
- IDLE: if any m_req is set, grant one master per the arbitration rule. Latch its addr, wdata and wr, plus the decode result. Go to ACCESS. With no request, stay in IDLE.
- Decode: lowest-index matching region wins when regions overlap. With no match, raise an error flag, keep s_sel=0 and suppress s_wr.
- ACCESS: hold s_sel/s_addr/s_wdata for WAIT_CYC+1 cycles, using a wait counter that starts at 0. In the last cycle:
  - pulse s_wr for writes;
  - capture s_rdata of the selected region into m_rdata for reads;
  - capture 0 for writes or decode errors.
  Then go to RESP.
- RESP: m_ack[grant]=1 for exactly one cycle, with m_err[grant]=error flag. Deassert s_sel. Return to IDLE.
- Request-to-ack latency is WAIT_CYC+3 cycles, counted from the first cycle m_req is sampled in IDLE. No back-to-back grant: at least one IDLE cycle between transactions.
- m_rdata holds its value until the next capture. m_ack and m_err are zero outside RESP.
- A master dropping m_req mid-transaction does not abort it; the ack is still issued.
- A new request from a master in the RESP cycle is ignored until IDLE.
- Asserting reset mid-transaction aborts immediately with no ack. The slave strobes are cleared asynchronously.

Optional Feature:
MEM_BUS_RR_ARB_EN:
- Defined: round-robin arbitration. The search starts at pointer+1 (mod N_MST). After each grant the pointer is set to the granted index.
- Undefined: fixed priority, lowest index wins (master 0 = instruction fetch). The pointer logic is not built.

Test Plan:
1. Reset then single read: master 1 reads 0x10010008, s_rdata region0=0xDEADBEEF, WAIT_CYC=1 -> s_sel=4'b0001 for 2 cycles, m_ack[1] exactly 4 cycles after m_req, m_rdata=0xDEADBEEF, m_err=0.
2. Write to stack: master 1 writes 0xCAFE0001 to 0x7FFFFFFC -> s_sel=4'b0010, s_wr pulses once in the last ACCESS cycle with s_wdata=0xCAFE0001; m_ack[1] with m_rdata=0.
3. Decode miss: read of 0x20000000 -> s_sel stays 0, s_wr never asserted; m_ack=1 with m_err=1 and m_rdata=0.
4. Contention: m_req=2'b11 held continuously -> RR_ARB_EN: grants alternate 0,1,0,1; without it, master 0 is served on every transaction.
5. Mid-transaction reset: assert rst=0 during ACCESS -> s_sel, s_wr and busy drop without a clock edge; no m_ack is issued; the first transaction after reset is granted normally.
6. WAIT_CYC=0 and WAIT_CYC=15 builds: MMIO read at 0xFFFF0004 -> s_sel=4'b1000; ack latency 3 and 18 cycles respectively.
